// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that shares one downstream bus port among
// NumMasters requesters. A winner's request is registered onto the shared
// port, the arbiter waits for the slave acknowledge (or a timeout), then
// returns a one-cycle m_ack with read data or an error to that requester.
//
// Handshake: a requester raises m_req and holds it until its m_ack pulse.
// Its m_we/m_addr/m_wdata only need to be stable at the IDLE capture edge.
// Downstream, s_req stays high with frozen s_* fields until s_ack is seen
// in a BUSY cycle. s_ack in any other state is ignored.
module bus_arbiter #(
    parameter int NumMasters    = 2,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NumMasters-1:0]           m_req,
    input  logic [NumMasters-1:0]           m_we,
    input  logic [NumMasters*AddrWidth-1:0] m_addr,
    input  logic [NumMasters*DataWidth-1:0] m_wdata,
    output logic [NumMasters-1:0]           m_ack,
    output logic [NumMasters-1:0]           m_err,
    output logic [DataWidth-1:0]            m_rdata,
    output logic                            s_req,
    output logic                            s_we,
    output logic [AddrWidth-1:0]            s_addr,
    output logic [DataWidth-1:0]            s_wdata,
    input  logic                            s_ack,
    input  logic [DataWidth-1:0]            s_rdata,
    output logic [$clog2(NumMasters)-1:0]   grant_id,
    output logic                            busy
);

    localparam int IdW = $clog2(NumMasters);

    // The timer needs at least one bit even when the timeout is disabled.
    localparam int TmrW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    // Timer value during the last permitted BUSY cycle.
    localparam logic [TmrW-1:0] TmrLast =
        (TimeoutCycles > 0) ? TmrW'(TimeoutCycles - 1) : '0;

    // Saturation value so the timer never wraps when the timeout is disabled.
    localparam logic [TmrW-1:0] TmrMax = '1;

    localparam bit TimeoutEn = (TimeoutCycles != 0);

    localparam logic [NumMasters-1:0] OneHot0 = NumMasters'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state;
    logic [IdW-1:0]    last;
    logic [TmrW-1:0]   timer;

    logic [IdW-1:0]    win_idx;
    logic              win_found;

    logic [AddrWidth-1:0] addr_arr  [NumMasters];
    logic [DataWidth-1:0] wdata_arr [NumMasters];

    // Split the packed request buses into per-requester fields.
    for (genvar g = 0; g < NumMasters; g++) begin : g_unpack
        assign addr_arr[g]  = m_addr[g*AddrWidth +: AddrWidth];
        assign wdata_arr[g] = m_wdata[g*DataWidth +: DataWidth];
    end

    // Round-robin pick: first requester found searching upward from last+1.
    always_comb begin : pick_winner
        logic [IdW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NumMasters; k++) begin
            cand = IdW'((int'(last) + k) % NumMasters);
            if (!win_found && m_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            last     <= IdW'(NumMasters - 1);
            timer    <= '0;
            s_req    <= 1'b0;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            m_ack    <= '0;
            m_err    <= '0;
            m_rdata  <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        s_we     <= m_we[win_idx];
                        s_addr   <= addr_arr[win_idx];
                        s_wdata  <= wdata_arr[win_idx];
                        s_req    <= 1'b1;
                        busy     <= 1'b1;
                        grant_id <= win_idx;
                        last     <= win_idx;
                        timer    <= '0;
                        state    <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (s_ack) begin
                        // A slave ack on the final timeout cycle still wins.
                        s_req   <= 1'b0;
                        m_rdata <= s_rdata;
                        m_ack   <= OneHot0 << grant_id;
                        m_err   <= '0;
                        state   <= ST_RESP;
                    end else if (TimeoutEn && (timer == TmrLast)) begin
                        s_req   <= 1'b0;
                        m_rdata <= '0;
                        m_ack   <= OneHot0 << grant_id;
                        m_err   <= OneHot0 << grant_id;
                        state   <= ST_RESP;
                    end else if (timer != TmrMax) begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_RESP: begin
                    m_ack <= '0;
                    m_err <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
